// File: rtl/discrete_mixer_pkg.sv
// Shared types and helpers for the discrete sound circuit mixer path.
// Holds the sample/gain types, the mixer state encoding and the 16-bit
// saturation helpers used by the mixer and the DC blocker.
package discrete_mixer_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [7:0]         gain_t;

    localparam int UNITY_GAIN = 128;
    localparam int GAIN_SHIFT = 7;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        SCALE,
        DCB
    } mix_state_t;

    function automatic sample_t sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'sh7fff;
        end else if (v < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    function automatic logic is_sat16(input logic signed [63:0] v);
        return (v > 64'sd32767) || (v < -64'sd32768);
    endfunction

endpackage

// File: rtl/discrete_dc_blocker.sv
// First-order high-pass (DC blocker) for 16-bit discrete circuit samples.
// y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), saturated to 16 bits.
// The output is combinational from the current input and stored history;
// history advances only when step is asserted.
module discrete_dc_blocker
    import discrete_mixer_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic    clk,
    input  logic    I_RST,
    input  logic    step,
    input  sample_t x,
    output sample_t y,
    output logic    sat
);

    sample_t            x_prev;
    sample_t            y_prev;
    logic signed [19:0] d_full;

    // Filter difference equation evaluated at full width, then clamped.
    always_comb begin
        d_full = 20'(x) - 20'(x_prev) + 20'(y_prev) - 20'(y_prev >>> DC_SHIFT);
        y      = sat16(64'(d_full));
        sat    = is_sat16(64'(d_full));
    end

    // History registers advance only on an accepted output sample.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (step) begin
            x_prev <= x;
            y_prev <= y;
        end
    end

endmodule

// File: rtl/discrete_audio_mixer.sv
// Mixes NUM_CH signed 16-bit discrete circuit outputs into one sample per
// audio_clk_en tick using a single time-multiplexed multiply-accumulate.
// Per-channel unsigned gain (128 = unity) and mute, saturating output,
// overrun flag when a tick arrives while a sample is still in flight.
// Optional DC blocker after scaling: define MIXER_DC_BLOCK_EN.
module discrete_audio_mixer
    import discrete_mixer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int GAIN_W   = 8,
    parameter int DC_SHIFT = 10
) (
    input  logic                  clk,
    input  logic                  I_RST,
    input  logic                  audio_clk_en,
    input  logic [NUM_CH*16-1:0]  in_flat,
    input  logic [NUM_CH*GAIN_W-1:0] gain_flat,
    input  logic [NUM_CH-1:0]     ch_mute,
    output sample_t               out,
    output logic                  out_valid,
    output logic                  clip,
    output logic                  overrun,
    output logic                  busy
);

    localparam int ACC_W  = 16 + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int PROD_W = 16 + GAIN_W + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 16 || DC_SHIFT < 1 || DC_SHIFT > 15) begin : g_bad_params
        $error("discrete_audio_mixer: parameter out of range");
    end

    mix_state_t               state;
    mix_state_t               state_nxt;
    logic                     capture;
    logic                     last_ch;
    logic [CH_W-1:0]          ch_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [PROD_W-1:0] prod;
    sample_t                  scale_y;
    logic                     scale_sat;

    sample_t                  snap_smp  [NUM_CH];
    logic [GAIN_W-1:0]        snap_gain [NUM_CH];
    logic [NUM_CH-1:0]        snap_mute;

`ifdef MIXER_DC_BLOCK_EN
    sample_t                  x_reg;
    logic                     x_clip;
    sample_t                  dc_y;
    logic                     dc_sat;

    discrete_dc_blocker #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk   (clk),
        .I_RST (I_RST),
        .step  (state == DCB),
        .x     (x_reg),
        .y     (dc_y),
        .sat   (dc_sat)
    );
`endif

    // A tick that arrives while a sample is in flight is dropped and flagged.
    assign overrun = audio_clk_en && (state != IDLE) && !I_RST;
    assign last_ch = (ch_idx == CH_W'(NUM_CH - 1));

    // State register; reset aborts any sample in progress.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencing: capture on tick, one channel per SUM cycle, then scale.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (audio_clk_en) begin
                    capture   = 1'b1;
                    state_nxt = SUM;
                end
            end
            SUM: begin
                if (last_ch) begin
                    state_nxt = SCALE;
                end
            end
            SCALE: begin
`ifdef MIXER_DC_BLOCK_EN
                state_nxt = DCB;
`else
                state_nxt = IDLE;
`endif
            end
            DCB:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Product of the selected channel and the scaled, saturated accumulator.
    always_comb begin
        if (snap_mute[ch_idx]) begin
            prod = '0;
        end else begin
            prod = PROD_W'(snap_smp[ch_idx]) * PROD_W'($signed({1'b0, snap_gain[ch_idx]}));
        end
        scaled    = acc >>> GAIN_SHIFT;
        scale_y   = sat16(64'(scaled));
        scale_sat = is_sat16(64'(scaled));
    end

    // Datapath: input snapshot, accumulation and output registers.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            acc       <= '0;
            ch_idx    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            busy      <= 1'b0;
            snap_mute <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_smp[k]  <= '0;
                snap_gain[k] <= '0;
            end
`ifdef MIXER_DC_BLOCK_EN
            x_reg     <= '0;
            x_clip    <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap_smp[k]  <= in_flat[16*k +: 16];
                            snap_gain[k] <= gain_flat[GAIN_W*k +: GAIN_W];
                        end
                        snap_mute <= ch_mute;
                        acc       <= '0;
                        ch_idx    <= '0;
                        busy      <= 1'b1;
                    end
                end
                SUM: begin
                    acc <= acc + ACC_W'(prod);
                    if (last_ch) begin
                        ch_idx <= '0;
                    end else begin
                        ch_idx <= ch_idx + CH_W'(1);
                    end
                end
                SCALE: begin
`ifdef MIXER_DC_BLOCK_EN
                    x_reg     <= scale_y;
                    x_clip    <= scale_sat;
`else
                    out       <= scale_y;
                    out_valid <= 1'b1;
                    clip      <= scale_sat;
                    busy      <= 1'b0;
`endif
                end
                DCB: begin
`ifdef MIXER_DC_BLOCK_EN
                    out       <= dc_y;
                    out_valid <= 1'b1;
                    clip      <= x_clip | dc_sat;
                    busy      <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_audio_mixer.sv
// Self-checking bench for discrete_audio_mixer: directed scenarios plus
// randomized samples compared against an arithmetic reference model.
module tb_discrete_audio_mixer;

    localparam int NUM_CH   = 4;
    localparam int GAIN_W   = 8;
    localparam int DC_SHIFT = 10;
`ifdef MIXER_DC_BLOCK_EN
    localparam int EXP_LAT  = NUM_CH + 3;
`else
    localparam int EXP_LAT  = NUM_CH + 2;
`endif

    logic                        clk;
    logic                        I_RST;
    logic                        audio_clk_en;
    logic [NUM_CH*16-1:0]        in_flat;
    logic [NUM_CH*GAIN_W-1:0]    gain_flat;
    logic [NUM_CH-1:0]           ch_mute;
    logic signed [15:0]          out;
    logic                        out_valid;
    logic                        clip;
    logic                        overrun;
    logic                        busy;

    int total = 0;
    int bad   = 0;

    longint m_xprev = 0;
    longint m_yd    = 0;

    discrete_audio_mixer #(
        .NUM_CH   (NUM_CH),
        .GAIN_W   (GAIN_W),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .in_flat      (in_flat),
        .gain_flat    (gain_flat),
        .ch_mute      (ch_mute),
        .out          (out),
        .out_valid    (out_valid),
        .clip         (clip),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint floor_div(input longint v, input longint d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Reference: exact weighted sum, floor divide by 128, clamp; optional HP filter.
    task automatic model_mix(input logic [63:0] smp, input logic [31:0] gn, input logic [3:0] mt,
                             output int y, output bit c);
        longint sum;
        longint q;
        sum = 0;
        c   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!mt[k]) sum += longint'($signed(smp[16*k +: 16])) * longint'(gn[8*k +: 8]);
        end
        q = floor_div(sum, 128);
        if (q > 32767) begin q = 32767; c = 1; end
        if (q < -32768) begin q = -32768; c = 1; end
`ifdef MIXER_DC_BLOCK_EN
        begin
            longint d;
            d = q - m_xprev + m_yd - floor_div(m_yd, longint'(1) << DC_SHIFT);
            if (d > 32767) begin d = 32767; c = 1; end
            if (d < -32768) begin d = -32768; c = 1; end
            m_xprev = q;
            m_yd    = d;
            q       = d;
        end
`endif
        y = int'(q);
    endtask

    task automatic do_reset;
        I_RST        = 1'b1;
        audio_clk_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        I_RST   = 1'b0;
        m_xprev = 0;
        m_yd    = 0;
    endtask

    // Drives one tick and observes the DUT for a bounded window afterwards.
    task automatic mix_one(input logic [63:0] smp, input logic [31:0] gn, input logic [3:0] mt,
                           input int ovr_at,
                           output logic signed [15:0] o, output logic c, output int lat,
                           output int nvalid, output int novr, output int ovr_cyc, output logic busy1);
        lat = -1; nvalid = 0; novr = 0; ovr_cyc = -1; o = '0; c = 1'b0; busy1 = 1'b0;
        @(posedge clk); #1;
        in_flat = smp; gain_flat = gn; ch_mute = mt; audio_clk_en = 1'b1;
        for (int cyc = 0; cyc <= EXP_LAT + 3; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                audio_clk_en = (cyc == ovr_at);
                in_flat      = {$urandom(), $urandom()};
                gain_flat    = $urandom();
                ch_mute      = 4'($urandom());
            end
            @(negedge clk);
            if (overrun) begin
                novr++;
                if (ovr_cyc < 0) ovr_cyc = cyc;
            end
            if (cyc == 1) busy1 = busy;
            if (out_valid) begin
                nvalid++;
                if (lat < 0) begin lat = cyc; o = out; c = clip; end
            end
        end
        audio_clk_en = 1'b0;
    endtask

    task automatic test_reset;
        I_RST        = 1'b1;
        audio_clk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        I_RST        = 1'b0;
        audio_clk_en = 1'b0;
        m_xprev = 0;
        m_yd    = 0;
        @(negedge clk);
        total++; if (out !== 16'sd0) begin bad++; $display("[TB] FAIL reset_out got=%0d exp=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (clip !== 1'b0) begin bad++; $display("[TB] FAIL reset_clip got=%b exp=0", clip); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_channel;
        logic signed [15:0] o; logic c, b1; int lat, nv, no, oc, y; bit ec;
        logic [63:0] smp;
        do_reset();
        smp = {16'sd5000, -16'sd7000, 16'sd123, 16'sd1000};
        model_mix(smp, {8'd200, 8'd90, 8'd255, 8'd128}, 4'b1110, y, ec);
        mix_one(smp, {8'd200, 8'd90, 8'd255, 8'd128}, 4'b1110, -1, o, c, lat, nv, no, oc, b1);
        total++; if (o !== 16'sd1000) begin bad++; $display("[TB] FAIL single_out got=%0d exp=1000", o); end
        total++; if (o !== y) begin bad++; $display("[TB] FAIL single_model got=%0d exp=%0d", o, y); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL single_latency got=%0d exp=%0d", lat, EXP_LAT); end
        total++; if (c !== 1'b0) begin bad++; $display("[TB] FAIL single_clip got=%b exp=0", c); end
        total++; if (b1 !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%b exp=1", b1); end
        total++; if (nv !== 1) begin bad++; $display("[TB] FAIL single_valid_count got=%0d exp=1", nv); end
    endtask

    task automatic test_saturation;
        logic signed [15:0] o; logic c, b1; int lat, nv, no, oc, y; bit ec;
        logic [63:0] smp;
        do_reset();
        smp = {4{16'sd16000}};
        model_mix(smp, {4{8'd128}}, 4'b0000, y, ec);
        mix_one(smp, {4{8'd128}}, 4'b0000, -1, o, c, lat, nv, no, oc, b1);
        total++; if (o !== 16'sd32767) begin bad++; $display("[TB] FAIL sat_pos_out got=%0d exp=32767", o); end
        total++; if (c !== 1'b1) begin bad++; $display("[TB] FAIL sat_pos_clip got=%b exp=1", c); end
        smp = {4{-16'sd16000}};
        model_mix(smp, {4{8'd128}}, 4'b0000, y, ec);
        mix_one(smp, {4{8'd128}}, 4'b0000, -1, o, c, lat, nv, no, oc, b1);
        total++; if (o !== 16'(y)) begin bad++; $display("[TB] FAIL sat_neg_out got=%0d exp=%0d", o, y); end
        total++; if (o !== -16'sd32768) begin bad++; $display("[TB] FAIL sat_neg_literal got=%0d exp=-32768", o); end
        total++; if (c !== 1'b1) begin bad++; $display("[TB] FAIL sat_neg_clip got=%b exp=1", c); end
    endtask

    task automatic test_floor;
        logic signed [15:0] o; logic c, b1; int lat, nv, no, oc, y; bit ec;
        do_reset();
        model_mix({48'h0, -16'sd3}, {24'h0, 8'd64}, 4'b1110, y, ec);
        mix_one({48'h0, -16'sd3}, {24'h0, 8'd64}, 4'b1110, -1, o, c, lat, nv, no, oc, b1);
        total++; if (o !== -16'sd2) begin bad++; $display("[TB] FAIL floor_neg got=%0d exp=-2", o); end
        do_reset();
        model_mix({48'h0, 16'sd3}, {24'h0, 8'd64}, 4'b1110, y, ec);
        mix_one({48'h0, 16'sd3}, {24'h0, 8'd64}, 4'b1110, -1, o, c, lat, nv, no, oc, b1);
        total++; if (o !== 16'sd1) begin bad++; $display("[TB] FAIL floor_pos got=%0d exp=1", o); end
        total++; if (c !== ec) begin bad++; $display("[TB] FAIL floor_clip got=%b exp=%b", c, ec); end
    endtask

    task automatic test_overrun;
        logic signed [15:0] o; logic c, b1; int lat, nv, no, oc, y; bit ec;
        logic [63:0] smp;
        smp = {16'sd400, -16'sd900, 16'sd2500, 16'sd77};
        model_mix(smp, {8'd10, 8'd128, 8'd250, 8'd33}, 4'b0000, y, ec);
        mix_one(smp, {8'd10, 8'd128, 8'd250, 8'd33}, 4'b0000, 2, o, c, lat, nv, no, oc, b1);
        total++; if (no !== 1) begin bad++; $display("[TB] FAIL ovr_count got=%0d exp=1", no); end
        total++; if (oc !== 2) begin bad++; $display("[TB] FAIL ovr_cycle got=%0d exp=2", oc); end
        total++; if (nv !== 1) begin bad++; $display("[TB] FAIL ovr_valid_count got=%0d exp=1", nv); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL ovr_latency got=%0d exp=%0d", lat, EXP_LAT); end
        total++; if (o !== 16'(y)) begin bad++; $display("[TB] FAIL ovr_out got=%0d exp=%0d", o, y); end
    endtask

    task automatic test_reset_mid;
        logic signed [15:0] o; logic c, b1; int lat, nv, no, oc, y, stray; bit ec;
        model_mix({48'h0, 16'sd1000}, {24'h0, 8'd128}, 4'b1110, y, ec);
        mix_one({48'h0, 16'sd1000}, {24'h0, 8'd128}, 4'b1110, -1, o, c, lat, nv, no, oc, b1);
        @(posedge clk); #1;
        in_flat = {4{16'sd9000}}; gain_flat = {4{8'd100}}; ch_mute = 4'b0000; audio_clk_en = 1'b1;
        @(posedge clk); #1; audio_clk_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; I_RST = 1'b1;
        @(posedge clk); #1; I_RST = 1'b0; m_xprev = 0; m_yd = 0;
        @(negedge clk);
        total++; if (out !== 16'sd0) begin bad++; $display("[TB] FAIL midrst_out got=%0d exp=0", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
        total++; if ({out_valid, clip, overrun} !== 3'b000) begin bad++; $display("[TB] FAIL midrst_flags got=%b exp=000", {out_valid, clip, overrun}); end
        stray = 0;
        for (int i = 0; i < EXP_LAT + 4; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("[TB] FAIL midrst_stray_valid got=%0d exp=0", stray); end
        model_mix({16'sd100, 16'sd200, 16'sd300, 16'sd400}, {4{8'd128}}, 4'b0000, y, ec);
        mix_one({16'sd100, 16'sd200, 16'sd300, 16'sd400}, {4{8'd128}}, 4'b0000, -1, o, c, lat, nv, no, oc, b1);
        total++; if (o !== 16'(y)) begin bad++; $display("[TB] FAIL midrst_next_out got=%0d exp=%0d", o, y); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL midrst_next_latency got=%0d exp=%0d", lat, EXP_LAT); end
    endtask

    task automatic test_random;
        logic signed [15:0] o; logic c, b1; int lat, nv, no, oc, y; bit ec;
        logic [63:0] smp; logic [31:0] gn; logic [3:0] mt;
        for (int n = 0; n < 30; n++) begin
            smp = {$urandom(), $urandom()};
            gn  = $urandom();
            mt  = 4'($urandom_range(0, 15));
            if (n % 5 == 0) mt = 4'b0000;
            model_mix(smp, gn, mt, y, ec);
            mix_one(smp, gn, mt, -1, o, c, lat, nv, no, oc, b1);
            total++; if (o !== 16'(y)) begin bad++; $display("[TB] FAIL rand_out[%0d] got=%0d exp=%0d", n, o, y); end
            total++; if (c !== ec) begin bad++; $display("[TB] FAIL rand_clip[%0d] got=%b exp=%b", n, c, ec); end
            total++; if (lat !== EXP_LAT || nv !== 1) begin bad++; $display("[TB] FAIL rand_timing[%0d] got lat=%0d n=%0d exp lat=%0d n=1", n, lat, nv, EXP_LAT); end
        end
    endtask

    task automatic test_constant_input;
        logic signed [15:0] o, prev; logic c, b1; int lat, nv, no, oc, y; bit ec;
        do_reset();
        prev = 16'sd32767;
        for (int n = 0; n < 6; n++) begin
            model_mix({48'h0, 16'sd8000}, {24'h0, 8'd128}, 4'b1110, y, ec);
            mix_one({48'h0, 16'sd8000}, {24'h0, 8'd128}, 4'b1110, -1, o, c, lat, nv, no, oc, b1);
            total++; if (o !== 16'(y)) begin bad++; $display("[TB] FAIL const_model[%0d] got=%0d exp=%0d", n, o, y); end
`ifdef MIXER_DC_BLOCK_EN
            if (n == 0) begin
                total++; if (o !== 16'sd8000) begin bad++; $display("[TB] FAIL const_first got=%0d exp=8000", o); end
            end else begin
                total++; if (!(o < prev)) begin bad++; $display("[TB] FAIL const_decay[%0d] got=%0d exp<%0d", n, o, prev); end
            end
`else
            total++; if (o !== 16'sd8000) begin bad++; $display("[TB] FAIL const_hold[%0d] got=%0d exp=8000", n, o); end
`endif
            prev = o;
        end
    endtask

    initial begin
        I_RST        = 1'b1;
        audio_clk_en = 1'b0;
        in_flat      = '0;
        gain_flat    = '0;
        ch_mute      = '0;
        test_reset();
        test_single_channel();
        test_saturation();
        test_floor();
        test_overrun();
        test_reset_mid();
        test_random();
        test_constant_input();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
